aib_link_bringup_ctrl: RTL

Sequences the AIB Gen2 follower link from reset to "online" for the single-channel AXI-MM bridge. The block drives the near-side adapter reset and MAC-ready handshakes into the AIB PHY. It waits for far-side reset release, per-channel transfer enables and RX alignment, then raises `tx_online`/`rx_online` toward the AXI-MM follower. Timeouts with bounded retry and link-loss recovery are included; it sits between the PHY control pins and the AXI-MM bridge in the `clk_wr` domain.

---
 rtl/aib_link_pkg.sv | 27 ++
 rtl/aib_link_bringup_ctrl_sync.sv | 26 ++
 rtl/aib_link_bringup_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/aib_link_pkg.sv
// Shared types and constants for the AIB Gen2 follower link bring-up controller.
package aib_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST_HOLD   = 3'd1,
    ST_WAIT_FS    = 3'd2,
    ST_WAIT_XFER  = 3'd3,
    ST_WAIT_ALIGN = 3'd4,
    ST_ONLINE     = 3'd5,
    ST_FAIL       = 3'd6
  } link_state_e;

  localparam int RETRY_W = 4;
  localparam int DROP_W  = 8;

  localparam int DEF_NBR_CHNLS    = 24;
  localparam int DEF_ACTIVE_CHNLS = 1;
  localparam int DEF_RST_HOLD_CYC = 16;
  localparam int DEF_TIMEOUT_CYC  = 4096;
  localparam int DEF_MAX_RETRY    = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aib_link_bringup_ctrl_sync.sv
// Parameterized-width 2-flop synchronizer with async active-low reset to zero.
module aib_sync2 #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/aib_link_bringup_ctrl.sv
// Brings the AIB follower link from reset to online, with timeout/retry and link-loss recovery.
module aib_link_bringup_ctrl
  import aib_link_pkg::*;
#(
  parameter int NBR_CHNLS    = DEF_NBR_CHNLS,
  parameter int ACTIVE_CHNLS = DEF_ACTIVE_CHNLS,
  parameter int RST_HOLD_CYC = DEF_RST_HOLD_CYC,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  input  logic                 enable,
  input  logic                 fs_adapter_rstn,
  input  logic                 fs_mac_rdy,
  input  logic [NBR_CHNLS-1:0] ms_tx_transfer_en,
  input  logic [NBR_CHNLS-1:0] sl_tx_transfer_en,
  input  logic                 m_rx_align_done,
  output logic                 ns_adapter_rstn,
  output logic                 ns_mac_rdy,
  output logic                 tx_online,
  output logic                 rx_online,
  output logic                 link_fail,
  output logic [RETRY_W-1:0]   retry_cnt,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic [2:0]           state
);

  localparam int CNT_MAX = max_int(TIMEOUT_CYC, RST_HOLD_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]           w_scalar_s;
  logic [NBR_CHNLS-1:0] w_ms_s;
  logic [NBR_CHNLS-1:0] w_sl_s;
  logic                 w_fs_rstn_s;
  logic                 w_fs_mac_s;
  logic                 w_align_s;
  logic                 w_xfer_ok;
  logic                 w_hold_done;
  logic                 w_timeout;

  link_state_e          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [RETRY_W-1:0]   r_retry;
  logic [DROP_W-1:0]    r_drop;
  logic                 r_ns_adapter_rstn;
  logic                 r_ns_mac_rdy;
  logic                 r_online;
  logic                 r_link_fail;

  link_state_e          w_next;
  logic [RETRY_W-1:0]   w_retry_next;
  logic [RETRY_W-1:0]   w_retry_inc;
  logic                 w_drop_inc;

  aib_sync2 #(.W(3)) u_sync_scalar (
    .i_clk   (clk_wr),
    .i_rst_n (rst_wr_n),
    .i_d     ({fs_adapter_rstn, fs_mac_rdy, m_rx_align_done}),
    .o_q     (w_scalar_s)
  );

  aib_sync2 #(.W(NBR_CHNLS)) u_sync_ms (
    .i_clk   (clk_wr),
    .i_rst_n (rst_wr_n),
    .i_d     (ms_tx_transfer_en),
    .o_q     (w_ms_s)
  );

  aib_sync2 #(.W(NBR_CHNLS)) u_sync_sl (
    .i_clk   (clk_wr),
    .i_rst_n (rst_wr_n),
    .i_d     (sl_tx_transfer_en),
    .o_q     (w_sl_s)
  );

  assign w_fs_rstn_s = w_scalar_s[2];
  assign w_fs_mac_s  = w_scalar_s[1];
  assign w_align_s   = w_scalar_s[0];
  assign w_xfer_ok   = &(w_ms_s[ACTIVE_CHNLS-1:0] & w_sl_s[ACTIVE_CHNLS-1:0]);

  // One counter serves both the reset-hold length and the wait-state timeout.
  assign w_hold_done = (r_cnt == CNT_W'(RST_HOLD_CYC - 1));
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_retry_inc = r_retry + RETRY_W'(1);

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_drop_inc   = 1'b0;
    if (!enable) begin
      w_next       = ST_IDLE;
      w_retry_next = '0;
    end else begin
      unique case (r_state)
        ST_IDLE:     w_next = ST_RST_HOLD;
        ST_RST_HOLD: if (w_hold_done) w_next = ST_WAIT_FS;
        ST_WAIT_FS, ST_WAIT_XFER, ST_WAIT_ALIGN: begin
          if (w_timeout) begin
            w_retry_next = w_retry_inc;
            w_next = (w_retry_inc == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_RST_HOLD;
          end else if (r_state == ST_WAIT_FS) begin
            if (w_fs_rstn_s && w_fs_mac_s) w_next = ST_WAIT_XFER;
          end else if (r_state == ST_WAIT_XFER) begin
            if (w_xfer_ok) w_next = ST_WAIT_ALIGN;
          end else if (w_align_s) begin
            w_next       = ST_ONLINE;
            w_retry_next = '0;
          end
        end
        ST_ONLINE: begin
          if (!(w_fs_rstn_s && w_fs_mac_s && w_xfer_ok && w_align_s)) begin
            w_next       = ST_RST_HOLD;
            w_retry_next = '0;
            w_drop_inc   = 1'b1;
          end
        end
        ST_FAIL:     w_next = ST_FAIL;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they move together with state.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_state           <= ST_IDLE;
      r_cnt             <= '0;
      r_retry           <= '0;
      r_drop            <= '0;
      r_ns_adapter_rstn <= 1'b0;
      r_ns_mac_rdy      <= 1'b0;
      r_online          <= 1'b0;
      r_link_fail       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_retry <= w_retry_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_W'(CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_drop_inc && (r_drop != {DROP_W{1'b1}})) begin
        r_drop <= r_drop + DROP_W'(1);
      end
      r_ns_adapter_rstn <= (w_next == ST_WAIT_FS) || (w_next == ST_WAIT_XFER) ||
                           (w_next == ST_WAIT_ALIGN) || (w_next == ST_ONLINE);
      r_ns_mac_rdy      <= (w_next == ST_WAIT_XFER) || (w_next == ST_WAIT_ALIGN) ||
                           (w_next == ST_ONLINE);
      r_online          <= (w_next == ST_ONLINE);
      r_link_fail       <= (w_next == ST_FAIL);
    end
  end

  assign ns_adapter_rstn = r_ns_adapter_rstn;
  assign ns_mac_rdy      = r_ns_mac_rdy;
  assign tx_online       = r_online;
  assign rx_online       = r_online;
  assign link_fail       = r_link_fail;
  assign retry_cnt       = r_retry;
  assign drop_cnt        = r_drop;
  assign state           = r_state;

endmodule
